// File: rtl/a2d_spi_master_pkg.sv
// a2d_pkg: shared constants and types for the ADC128S SPI conversion master.
package a2d_pkg;

  typedef enum logic [1:0] {IDLE, XFER1, GAP, XFER2} a2d_state_t;

  localparam logic [4:0]  SCLK_PRELOAD = 5'b10000;
  localparam int          XFER_BITS    = 16;
  localparam int          GAP_CLKS     = 32;
  localparam logic [10:0] CMD_PAD      = 11'h000;

  // Channel command word; the ADC reads its address from bits [13:11].
  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, CMD_PAD};
  endfunction

endpackage

// File: rtl/a2d_spi_master_if.sv
// a2d_spi_master_if: four-wire SPI bus between the conversion master and the ADC128S.
interface a2d_spi_master_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/a2d_spi_master_spi_mstr16.sv
// spi_mstr16: generic 16-bit SPI shifter, SCLK = clk/32, idles high.
// wrt loads cmd and drops SS_n; done pulses on the closing fall point,
// where rd_data already includes the final received bit.
module spi_mstr16
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  localparam logic [4:0] LAST_SMPL = 5'(XFER_BITS);

  logic [15:0] shft;
  logic [4:0]  sclk_div;
  logic [4:0]  smpl_cnt;
  logic        miso_ff;
  logic        ss_q;

  logic rise_pt, fall_pt;

  assign rise_pt = !ss_q && (sclk_div == 5'b01111);
  assign fall_pt = !ss_q && (sclk_div == 5'b11111);
  assign done    = fall_pt && (smpl_cnt == LAST_SMPL);
  assign rd_data = {shft[14:0], miso_ff};

  // SS_n high forces SCLK high so the bus idles cleanly between frames
  assign SCLK = sclk_div[4] | ss_q;
  assign SS_n = ss_q;
  assign MOSI = shft[15];

  // Frame sequencing: load, count SCLK phases, sample on rise, shift on fall
  always_ff @(posedge clk) begin
    if (rst) begin
      shft     <= '0;
      sclk_div <= '0;
      smpl_cnt <= '0;
      miso_ff  <= 1'b0;
      ss_q     <= 1'b1;
    end else if (wrt) begin
      shft     <= cmd;
      sclk_div <= SCLK_PRELOAD;
      smpl_cnt <= '0;
      ss_q     <= 1'b0;
    end else if (!ss_q) begin
      sclk_div <= sclk_div + 5'd1;
      if (rise_pt) begin
        miso_ff  <= MISO;
        smpl_cnt <= smpl_cnt + 5'd1;
      end
      // first fall point (smpl_cnt==0) is the front porch: nothing to shift yet
      if (fall_pt && (smpl_cnt != 5'd0))
        shft <= rd_data;
      if (done) begin
        ss_q     <= 1'b1;
        sclk_div <= '0;
        smpl_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/a2d_spi_master.sv
// a2d_spi_master: one ADC128S conversion per strt_cnv, as two 16-bit frames
// separated by a 32-clock SS_n-high gap. Frame 1 sets the channel, frame 2
// returns the 12-bit result.
// Optional build macro A2D_RES_INVERT_EN: res takes the inverted result bits.
module a2d_spi_master
  import a2d_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     strt_cnv,
  input  logic [2:0]               chnnl,
  output logic                     cnv_cmplt,
  output logic [11:0]              res,
  a2d_spi_master_if.master         spi
);

  localparam logic [4:0] GAP_LAST = 5'(GAP_CLKS - 1);

  a2d_state_t  state;
  logic [4:0]  gap_cnt;
  logic [2:0]  chnnl_q;

  logic        wrt, done;
  logic [15:0] cmd, rd_data;
  logic [11:0] res_nxt;
  logic        unused_rd_hi;

  // In IDLE the shifter must see the channel on the same edge it is captured
  assign cmd = a2d_cmd((state == IDLE) ? chnnl : chnnl_q);
  assign wrt = ((state == IDLE) && strt_cnv) ||
               ((state == GAP) && (gap_cnt == GAP_LAST));

`ifdef A2D_RES_INVERT_EN
  assign res_nxt = ~rd_data[11:0];
`else
  assign res_nxt = rd_data[11:0];
`endif
  assign unused_rd_hi = ^rd_data[15:12];

  spi_mstr16 u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (spi.MISO),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (spi.SS_n),
    .SCLK    (spi.SCLK),
    .MOSI    (spi.MOSI)
  );

  // Conversion FSM: command frame, gap, result frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      chnnl_q   <= '0;
      res       <= '0;
      cnv_cmplt <= 1'b0;
    end else begin
      case (state)
        IDLE: if (strt_cnv) begin
          chnnl_q   <= chnnl;
          cnv_cmplt <= 1'b0;
          state     <= XFER1;
        end
        XFER1: if (done) begin
          gap_cnt <= '0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= XFER2;
          end else begin
            gap_cnt <= gap_cnt + 5'd1;
          end
        end
        XFER2: if (done) begin
          res       <= res_nxt;
          cnv_cmplt <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_master.sv
// tb_a2d_spi_master: directed bench with an ADC128S bus model and a bus monitor.
module tb_a2d_spi_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt_cnv = 1'b0;
  logic [2:0]  chnnl = 3'd0;
  logic        cnv_cmplt;
  logic [11:0] res;

  int tests = 0;
  int fails = 0;

  a2d_spi_master_if spi ();

  a2d_spi_master dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res),
    .spi       (spi)
  );

  always #5 clk = ~clk;

  // ADC128S model: address taken from the previous frame's DIN[13:11],
  // data {4'h0, sample} shifted out MSB first on SCLK falls.
  logic [11:0] analog_mem [0:7];
  logic [2:0]  adc_addr = 3'd0;
  logic [15:0] adc_out  = 16'h0;
  logic [15:0] adc_din  = 16'h0;
  int          adc_bit  = 0;

  always @(negedge spi.SS_n) begin
    adc_out = {4'h0, analog_mem[adc_addr]};
    adc_bit = 0;
    adc_din = 16'h0;
  end
  always @(posedge spi.SCLK) if (spi.SS_n === 1'b0) begin
    adc_din = {adc_din[14:0], spi.MOSI};
    adc_bit++;
  end
  always @(negedge spi.SCLK) if (spi.SS_n === 1'b0)
    spi.MISO = (adc_bit < 16) ? adc_out[4'(15 - adc_bit)] : 1'b0;
  always @(posedge spi.SS_n) adc_addr = adc_din[13:11];

  // Bus monitor sampled mid-cycle
  int          cyc = 0, t_fall = 0, t_rise = 0, rise_cnt = 0;
  int          sclk_viol = 0, mosi_viol = 0;
  bit          have_rise = 1'b0;
  logic        p_ss = 1'b1, p_sclk = 1'b1, p_mosi = 1'b0, p_rst = 1'b0;
  logic [15:0] msr = 16'h0;
  int          lows[$], gaps[$], rises[$];
  logic [15:0] words[$];

  always @(negedge clk) begin
    cyc++;
    if (spi.SS_n === 1'b1 && spi.SCLK !== 1'b1) sclk_viol++;
    if (spi.MOSI !== p_mosi && !(p_sclk === 1'b1 && spi.SCLK === 1'b0) &&
        spi.SS_n === p_ss && !rst && !p_rst) mosi_viol++;
    if (p_ss === 1'b1 && spi.SS_n === 1'b0) begin
      if (have_rise) gaps.push_back(cyc - t_rise);
      t_fall = cyc; rise_cnt = 0; msr = 16'h0;
    end
    if (p_ss === 1'b0 && spi.SS_n === 1'b1) begin
      lows.push_back(cyc - t_fall); rises.push_back(rise_cnt); words.push_back(msr);
      t_rise = cyc; have_rise = 1'b1;
    end
    if (spi.SS_n === 1'b0 && p_sclk === 1'b0 && spi.SCLK === 1'b1) begin
      rise_cnt++; msr = {msr[14:0], spi.MOSI};
    end
    p_ss = spi.SS_n; p_sclk = spi.SCLK; p_mosi = spi.MOSI; p_rst = rst;
  end

  function automatic logic [11:0] exp_res(input logic [11:0] v);
`ifdef A2D_RES_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one strt_cnv pulse; returns at E0+1
  task automatic start(input logic [2:0] ch);
    chnnl = ch; strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
  endtask

  logic        ss_h   [0:2047];
  logic        sclk_h [0:2047];
  logic [11:0] res_mid;

  task automatic wait_cmplt(input int n0, output int n);
    n = n0;
    ss_h[n] = spi.SS_n; sclk_h[n] = spi.SCLK;
    while (cnv_cmplt !== 1'b1 && n < 2000) begin
      tick(); n++;
      ss_h[n] = spi.SS_n; sclk_h[n] = spi.SCLK;
      if (n == 500) res_mid = res;
    end
  endtask

  int n, qi, gi;

  initial begin
    analog_mem[0] = 12'h123; analog_mem[1] = 12'h1F0; analog_mem[2] = 12'h321;
    analog_mem[3] = 12'hABC; analog_mem[4] = 12'h444; analog_mem[5] = 12'h5A5;
    analog_mem[6] = 12'h666; analog_mem[7] = 12'h777;

    // Reset state
    tick(); tick();
    chk("rst_ss_n", 32'(spi.SS_n), 32'd1);
    chk("rst_sclk", 32'(spi.SCLK), 32'd1);
    chk("rst_mosi", 32'(spi.MOSI), 32'd0);
    chk("rst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("rst_res", 32'(res), 32'h0);
    rst = 1'b0;
    tick();

    // Basic conversion, channel 3, cycle-exact framing
    start(3'd3);
    wait_cmplt(0, n);
    chk("basic_latency", 32'(n), 32'd1088);
    chk("basic_res", 32'(res), 32'(exp_res(12'hABC)));
    chk("ss_fall_e0", 32'(ss_h[0]), 32'd0);
    chk("sclk_e15", 32'(sclk_h[15]), 32'd1);
    chk("sclk_e16", 32'(sclk_h[16]), 32'd0);
    chk("sclk_e31", 32'(sclk_h[31]), 32'd0);
    chk("sclk_e32", 32'(sclk_h[32]), 32'd1);
    chk("ss_e527", 32'(ss_h[527]), 32'd0);
    chk("ss_e528", 32'(ss_h[528]), 32'd1);
    chk("ss_e559", 32'(ss_h[559]), 32'd1);
    chk("ss_e560", 32'(ss_h[560]), 32'd0);
    chk("ss_e1087", 32'(ss_h[1087]), 32'd0);
    chk("ss_e1088", 32'(ss_h[1088]), 32'd1);
    @(negedge clk); #1;

    // Command encoding and framing widths, channel 5
    qi = lows.size(); gi = gaps.size();
    start(3'd5);
    wait_cmplt(0, n);
    @(negedge clk); #1;
    chk("ch5_latency", 32'(n), 32'd1088);
    chk("ch5_res", 32'(res), 32'(exp_res(12'h5A5)));
    chk("ch5_nframes", 32'(lows.size() - qi), 32'd2);
    if (lows.size() >= qi + 2 && gaps.size() >= gi + 2) begin
      chk("ch5_low1", 32'(lows[qi]), 32'd528);
      chk("ch5_low2", 32'(lows[qi+1]), 32'd528);
      chk("ch5_gap", 32'(gaps[gi+1]), 32'd32);
      chk("ch5_rises1", 32'(rises[qi]), 32'd16);
      chk("ch5_rises2", 32'(rises[qi+1]), 32'd16);
      chk("ch5_cmd1", 32'(words[qi]), 32'h2800);
      chk("ch5_cmd2", 32'(words[qi+1]), 32'h2800);
    end

    // Busy strt_cnv with another channel is ignored
    qi = lows.size();
    start(3'd1);
    repeat (299) tick();
    chnnl = 3'd6; strt_cnv = 1'b1;
    tick();
    strt_cnv = 1'b0;
    wait_cmplt(300, n);
    @(negedge clk); #1;
    chk("busy_latency", 32'(n), 32'd1088);
    chk("busy_res", 32'(res), 32'(exp_res(12'h1F0)));
    if (words.size() >= qi + 2) begin
      chk("busy_cmd1", 32'(words[qi]), 32'h0800);
      chk("busy_cmd2", 32'(words[qi+1]), 32'h0800);
    end else chk("busy_nframes", 32'(words.size() - qi), 32'd2);

    // Restart after completion: cmplt clears at acceptance, res holds
    start(3'd2);
    chk("restart_cmplt_clr", 32'(cnv_cmplt), 32'd0);
    chk("restart_res_hold0", 32'(res), 32'(exp_res(12'h1F0)));
    wait_cmplt(0, n);
    chk("restart_res_hold500", 32'(res_mid), 32'(exp_res(12'h1F0)));
    chk("restart_latency", 32'(n), 32'd1088);
    chk("restart_res", 32'(res), 32'(exp_res(12'h321)));
    tick();

    // Reset in the middle of the second frame
    start(3'd4);
    repeat (699) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ss_n", 32'(spi.SS_n), 32'd1);
    chk("midrst_sclk", 32'(spi.SCLK), 32'd1);
    chk("midrst_mosi", 32'(spi.MOSI), 32'd0);
    chk("midrst_cmplt", 32'(cnv_cmplt), 32'd0);
    chk("midrst_res", 32'(res), 32'h0);
    rst = 1'b0;
    tick(); tick();
    start(3'd7);
    wait_cmplt(0, n);
    chk("post_rst_latency", 32'(n), 32'd1088);
    chk("post_rst_res", 32'(res), 32'(exp_res(12'h777)));

    // Channel 0: under A2D_RES_INVERT_EN this yields 12'hEDC
    tick();
    start(3'd0);
    wait_cmplt(0, n);
    chk("ch0_res", 32'(res), 32'(exp_res(12'h123)));
    tick(); tick();

    // Whole-run bus invariants
    chk("sclk_high_when_idle", 32'(sclk_viol), 32'd0);
    chk("mosi_only_on_fall", 32'(mosi_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
